// File: rtl/fsm_ctrl_pkg.sv
// rtl/fsm_ctrl_pkg.sv - shared IDLE/RUN/DONE state encoding for the FSM control blocks
package fsm_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/run_cnt_ctrl_if.sv
// rtl/run_cnt_ctrl_if.sv - strobe/status bundle between host and run controller
interface run_cnt_ctrl_if #(
  parameter int CNT_W = 7
);

  logic             i_run;
  logic [CNT_W-1:0] i_num_cnt;
  logic             i_stop;
  logic             o_idle;
  logic             o_running;
  logic             o_done;
  logic [CNT_W-1:0] o_cnt;

  modport master (
    output i_run, i_num_cnt, i_stop,
    input  o_idle, o_running, o_done, o_cnt
  );

  modport slave (
    input  i_run, i_num_cnt, i_stop,
    output o_idle, o_running, o_done, o_cnt
  );

endinterface

// File: rtl/run_cnt_ctrl.sv
// rtl/run_cnt_ctrl.sv - enables a datapath for exactly N cycles, then pulses done
module run_cnt_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  run_cnt_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             start;
  logic             is_done;
  logic             idle_o, running_o, done_o;
  logic [CNT_W-1:0] cnt_o;

  // A zero count is not a run; stop always beats run.
  assign start   = (state_q == S_IDLE) && bus.i_run && (bus.i_num_cnt != '0) && !bus.i_stop;
  assign is_done = (state_q == S_RUN) && (cnt_q == num_q - CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_RUN : S_IDLE;
      S_RUN: begin
        if (bus.i_stop) begin
          state_d = S_IDLE;
        end else if (is_done) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle_o    = 1'b0;
    running_o = 1'b0;
    done_o    = 1'b0;
    cnt_o     = '0;
    case (state_q)
      S_IDLE:  idle_o = 1'b1;
      S_RUN: begin
        running_o = 1'b1;
        cnt_o     = cnt_q;
      end
      S_DONE:  done_o = 1'b1;
      default: idle_o = 1'b1;
    endcase
  end

  // Counter only advances inside RUN; every exit path leaves it cleared.
  always_comb begin
    cnt_d = '0;
    num_d = num_q;
    if (start) begin
      num_d = bus.i_num_cnt;
    end
    if ((state_q == S_RUN) && !bus.i_stop && !is_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      num_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      num_q <= num_d;
    end
  end

  assign bus.o_idle    = idle_o;
  assign bus.o_running = running_o;
  assign bus.o_done    = done_o;
  assign bus.o_cnt     = cnt_o;

endmodule

// File: tb/tb_run_cnt_ctrl.sv
// tb/tb_run_cnt_ctrl.sv - scoreboard bench for run_cnt_ctrl against a cycle-timing model
module tb_run_cnt_ctrl;

  localparam int CW = 7;

  typedef struct {
    logic          idle;
    logic          running;
    logic          done;
    logic [CW-1:0] cnt;
    int            cyc;
  } exp_t;

  logic clk;
  logic reset_n;

  run_cnt_ctrl_if #(.CNT_W(CW)) bus ();

  run_cnt_ctrl #(.CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_dones = 0;
  int   seen_dones = 0;
  int   cyc = 0;

  // Model: a run accepted at cycle ts with count tn occupies cycles ts+1..ts+tn (RUN)
  // and ts+tn+1 (DONE); everything else is idle.
  bit   act = 0;
  int   ts  = 0;
  int   tn  = 0;

  function automatic bit m_run(int c);
    return act && (c - ts >= 1) && (c - ts <= tn);
  endfunction

  function automatic bit m_idle(int c);
    return !(act && (c - ts >= 1) && (c - ts <= tn + 1));
  endfunction

  function automatic exp_t m_at(int c);
    exp_t e;
    e.idle = 1'b0; e.running = 1'b0; e.done = 1'b0; e.cnt = '0; e.cyc = c;
    if (m_run(c)) begin
      e.running = 1'b1;
      e.cnt     = CW'(c - ts - 1);
    end else if (act && (c - ts == tn + 1)) begin
      e.done = 1'b1;
    end else begin
      e.idle = 1'b1;
    end
    return e;
  endfunction

  task automatic step(input logic run, input logic [CW-1:0] num, input logic stop);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n       = 1'b1;
    bus.i_run     = run;
    bus.i_num_cnt = num;
    bus.i_stop    = stop;
    e = m_at(cyc);
    exp_q.push_back(e);
    if (e.done) exp_dones++;
    if (m_idle(cyc) && run && (num != 0) && !stop) begin
      act = 1; ts = cyc; tn = int'(num);
    end else if (m_run(cyc) && stop) begin
      act = 0;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, CW'(0), 1'b0);
  endtask

  // Reset asserted 2 time units after the edge, i.e. between edges.
  task automatic rst_cycles(input int k);
    exp_t e;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      bus.i_run = 1'b0; bus.i_num_cnt = '0; bus.i_stop = 1'b0;
      act = 0;
      e = m_at(cyc);
      exp_q.push_back(e);
      #1 reset_n = 1'b0;
      cyc++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.o_done) seen_dones++;
      if (bus.o_idle !== e.idle || bus.o_running !== e.running ||
          bus.o_done !== e.done || bus.o_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d: got idle=%b run=%b done=%b cnt=%0d, want idle=%b run=%b done=%b cnt=%0d",
                 e.cyc, bus.o_idle, bus.o_running, bus.o_done, bus.o_cnt,
                 e.idle, e.running, e.done, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    bus.i_run     = 1'b0;
    bus.i_num_cnt = '0;
    bus.i_stop    = 1'b0;

    rst_cycles(3);
    idle_steps(10);

    step(1'b1, CW'(5), 1'b0);
    idle_steps(8);

    step(1'b1, CW'(1), 1'b0);
    idle_steps(4);
    step(1'b1, CW'(127), 1'b0);
    idle_steps(130);
    step(1'b1, CW'(0), 1'b0);
    idle_steps(4);

    // Requests during RUN (T+3) and DONE (T+6) are dropped.
    step(1'b1, CW'(5), 1'b0);
    idle_steps(2);
    step(1'b1, CW'(9), 1'b0);
    idle_steps(2);
    step(1'b1, CW'(9), 1'b0);
    idle_steps(12);

    step(1'b1, CW'(10), 1'b0);
    idle_steps(3);
    step(1'b0, CW'(0), 1'b1);
    idle_steps(3);
    step(1'b1, CW'(6), 1'b1);
    idle_steps(3);
    step(1'b1, CW'(4), 1'b0);
    idle_steps(3);
    step(1'b0, CW'(0), 1'b1);
    idle_steps(3);

    // Back-to-back: next start in the first IDLE cycle after DONE.
    step(1'b1, CW'(3), 1'b0);
    idle_steps(4);
    step(1'b1, CW'(2), 1'b0);
    idle_steps(4);

    step(1'b1, CW'(20), 1'b0);
    idle_steps(7);
    rst_cycles(3);
    step(1'b1, CW'(3), 1'b0);
    idle_steps(6);

    for (int i = 0; i < 600; i++) begin
      logic          r, s;
      logic [CW-1:0] n;
      r = ($urandom % 3) == 0;
      n = (($urandom % 20) == 0) ? CW'($urandom_range(0, 127)) : CW'($urandom_range(0, 12));
      s = ($urandom % 15) == 0;
      step(r, n, s);
    end
    idle_steps(140);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    n_checks++;
    if (seen_dones != exp_dones) begin
      n_fail++;
      $display("FAIL done_count: got %0d done pulses, want %0d", seen_dones, exp_dones);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_cnt_ctrl.md
# run_cnt_ctrl

Three-state run controller that sequences a counting core: accepts a one-cycle run request carrying a loop count, steps an internal counter through that many cycles, then reports completion with a one-cycle done pulse. It supplies the real `is_done` condition for the IDLE/RUN/DONE control pattern used across the FSM blocks. It sits between a host/testbench strobe interface and any datapath that must be enabled for exactly N cycles.

## Interface
- `CNT_W`, default 7, width of the loop count and counter index (max count 2^CNT_W − 1).
- `clk`  in  1  clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_run`  in  1  start strobe; sampled only in IDLE.
- `i_num_cnt`  in  CNT_W  number of RUN cycles; sampled with `i_run`.
- `i_stop`  in  1  abort request; sampled in IDLE and RUN.
- `o_idle`  out  1  high while state is IDLE.
- `o_running`  out  1  high while state is RUN; datapath enable.
- `o_done`  out  1  one-cycle pulse while state is DONE.
- `o_cnt`  out  CNT_W  current iteration index, 0 … N−1 during RUN.

## Operation
- States: S_IDLE, S_RUN, S_DONE; registered current state, combinational next state, Moore outputs.
- IDLE → RUN when `i_run`=1, `i_num_cnt`≠0, `i_stop`=0; latch `i_num_cnt` into `num_r`, clear counter.
- IDLE with `i_run`=1 and `i_num_cnt`=0: request ignored, stay IDLE, no `o_done`.
- RUN: counter increments by 1 each cycle; `is_done` = (counter == `num_r` − 1), combinational.
- RUN → DONE when `is_done`=1 and `i_stop`=0.
- RUN → IDLE when `i_stop`=1 (abort), regardless of `is_done`; no `o_done`; counter cleared.
- DONE → IDLE unconditionally; `i_run`, `i_stop` ignored in DONE.
- `i_run` in RUN or DONE ignored (not queued); `i_num_cnt` changes outside the IDLE sampling cycle have no effect.
- `i_stop` and `i_run` together in IDLE: stop wins, stay IDLE.
- Undefined state encoding (2'b11): next state IDLE, all outputs at reset values.
- Counter arithmetic unsigned CNT_W bits; never wraps because RUN exits at `num_r` − 1 ≤ 2^CNT_W − 2.
- `o_cnt` shows the counter in RUN, 0 in all other states.

## Timing
- Reset (async assert): state S_IDLE, `num_r`=0, counter=0 → `o_idle`=1, `o_running`=0, `o_done`=0, `o_cnt`=0.
- Release of `reset_n` synchronous to clk by the instantiating level; block takes no action on the release edge except normal sampling.
- Start at cycle T (`i_run` high): RUN in cycles T+1 … T+N, `o_cnt` = 0 … N−1; `o_done` high exactly cycle T+N+1; IDLE (`o_idle`=1) from T+N+2.
- Earliest back-to-back start: `i_run` at T+N+2 → RUN at T+N+3. Command-to-command period N+2 cycles.
- Abort: `i_stop` at RUN cycle S → IDLE at S+1, `o_cnt`=0 at S+1.
- Reset asserted mid-RUN or in DONE: immediate return to reset values, no `o_done`.

## Structure
- Shared package `fsm_ctrl_pkg`: state encodings S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10, state width 2; reused by later FSM blocks.
- Single module, three always blocks (state register, next-state logic, output logic) plus one counter/`num_r` register block; no sub-module needed.
- Next-state and output blocks assign defaults first (S_IDLE / zeros) so no latches are inferred.

## Test plan
- Reset then idle: hold `reset_n`=0 3 cycles, release → `o_idle`=1, `o_running`=0, `o_done`=0, `o_cnt`=0 steady for 10 cycles.
- Normal run: `i_run`=1, `i_num_cnt`=5 at T → `o_running`=1 T+1…T+5, `o_cnt` 0,1,2,3,4; `o_done`=1 only at T+6; `o_idle`=1 at T+7.
- Boundary counts: N=1 → single RUN cycle with `o_cnt`=0, done at T+2; N=127 (CNT_W=7) → `o_cnt` reaches 126, done at T+128; N=0 → stays IDLE, no done.
- Ignored requests: second `i_run` with `i_num_cnt`=9 at T+3 of a N=5 run, and `i_run` during DONE → original timing unchanged, no second run started.
- Abort and simultaneous events: N=10, `i_stop` at T+4 → IDLE at T+5, no `o_done`; `i_run`+`i_stop` together in IDLE → stays IDLE; `i_stop` in final RUN cycle (`o_cnt`=N−1) → IDLE, no `o_done`.
- Reset mid-operation: N=20, assert `reset_n`=0 asynchronously at T+8 (between edges) → outputs return to reset values immediately; after release, new run N=3 completes with done at its T'+4.
